// File: rtl/noc_pkg.sv
// ============================================================================
// Module : noc_pkg
// Brief  : Shared NoC router definitions: port indices, arbiter FSM states,
//          flit-type encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

package noc_pkg;
  localparam int P_N    = 0;
  localparam int P_E    = 1;
  localparam int P_W    = 2;
  localparam int P_S    = 3;
  localparam int P_L    = 4;
  localparam int NPORTS = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;
endpackage

`default_nettype wire

// File: rtl/lbdr_out_arbiter_if.sv
// ============================================================================
// Module : lbdr_out_arbiter_if
// Brief  : Request/flow-control bundle between input FIFOs and one output
//          arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface lbdr_out_arbiter_if #(
  parameter int CW = 3
);
  import noc_pkg::*;

  logic [NPORTS-1:0]   req;
  logic [NPORTS-1:0]   empty;
  logic [3*NPORTS-1:0] flit_id;
  logic                credit_in;
  logic [NPORTS-1:0]   rd_en;
  logic                valid_out;
  logic [2:0]          xbar_sel;
  logic [NPORTS-1:0]   grant;
  logic [CW-1:0]       credits;

  modport slave (
    input  req, empty, flit_id, credit_in,
    output rd_en, valid_out, xbar_sel, grant, credits
  );

  modport master (
    output req, empty, flit_id, credit_in,
    input  rd_en, valid_out, xbar_sel, grant, credits
  );
endinterface

`default_nettype wire

// File: rtl/lbdr_out_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational 5-way rotating priority encoder; searches upward
//          from ptr with wrap 4->0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
  import noc_pkg::*;
(
  input  logic [NPORTS-1:0] eligible,
  input  logic [2:0]        ptr,
  output logic              any,
  output logic [2:0]        idx,
  output logic [NPORTS-1:0] onehot
);

  logic [2:0] cand;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any    = 1'b0;
    idx    = 3'd0;
    onehot = '0;
    cand   = 3'd0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      cand = 3'((int'(ptr) + k) % NPORTS);
      if (eligible[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    onehot[idx] = any;
  end

endmodule

`default_nettype wire

// File: rtl/lbdr_out_arbiter.sv
// ============================================================================
// Module : lbdr_out_arbiter
// Brief  : Per-output round-robin arbiter with wormhole locking and
//          credit-based flow control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module lbdr_out_arbiter
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  lbdr_out_arbiter_if.slave  bus
);

  arb_state_t        r_state, w_state_n;
  logic [2:0]        r_ptr, w_ptr_n;
  logic [2:0]        r_sel, w_sel_n;
  logic [NPORTS-1:0] r_grant, w_grant_n;
  logic [CW-1:0]     r_credits, w_credits_n;

  logic [2:0]        w_fid [NPORTS];
  logic [NPORTS-1:0] w_elig;
  logic              w_any;
  logic [2:0]        w_idx;
  logic [NPORTS-1:0] w_onehot;
  logic              w_xfer;
  logic [2:0]        w_fid_g;

  for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
    assign w_fid[i]  = bus.flit_id[3*i +: 3];
    assign w_elig[i] = bus.req[i] & ~bus.empty[i] & (w_fid[i] == `HEADER);
  end

  rr_pick u_pick (
    .eligible (w_elig),
    .ptr      (r_ptr),
    .any      (w_any),
    .idx      (w_idx),
    .onehot   (w_onehot)
  );

  assign w_fid_g = w_fid[r_sel];
  // Reset also masks the read strobe so no FIFO pops while the lock is dropped.
  assign w_xfer  = ~rst & (r_state == LOCK) & ~bus.empty[r_sel] & (r_credits != '0);

  assign bus.rd_en     = w_xfer ? r_grant : '0;
  assign bus.valid_out = |bus.rd_en;
  assign bus.grant     = r_grant;
  assign bus.xbar_sel  = r_sel;
  assign bus.credits   = r_credits;

  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_sel_n   = r_sel;
    w_ptr_n   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_n = LOCK;
          w_grant_n = w_onehot;
          w_sel_n   = w_idx;
        end
      end
      LOCK: begin
        if (w_xfer && (w_fid_g == `TAIL)) begin
          w_state_n = IDLE;
          w_grant_n = '0;
          w_ptr_n   = (r_sel == 3'(NPORTS - 1)) ? 3'd0 : r_sel + 3'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_credits_n = r_credits;
    case ({w_xfer, bus.credit_in})
      2'b10:   w_credits_n = r_credits - 1'b1;
      2'b01:   if (r_credits != CW'(DEPTH)) w_credits_n = r_credits + 1'b1;
      default: w_credits_n = r_credits;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 3'd0;
      r_sel     <= 3'd0;
      r_grant   <= '0;
      r_credits <= CW'(DEPTH);
    end else begin
      r_state   <= w_state_n;
      r_ptr     <= w_ptr_n;
      r_sel     <= w_sel_n;
      r_grant   <= w_grant_n;
      r_credits <= w_credits_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lbdr_out_arbiter.sv
// ============================================================================
// Module : tb_lbdr_out_arbiter
// Brief  : Directed self-checking bench for lbdr_out_arbiter (DEPTH=4 and
//          DEPTH=2 instances).
// Rev    : 1.1  check task
// ============================================================================
`default_nettype none

`ifndef HEADER
`define HEADER  3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL    3'b100
`endif

module tb_lbdr_out_arbiter;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lbdr_out_arbiter_if #(.CW(3)) b  ();
    lbdr_out_arbiter_if #(.CW(2)) b2 ();

    lbdr_out_arbiter #(.DEPTH(4), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    lbdr_out_arbiter #(.DEPTH(2), .CW(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic r, input logic e, input logic [2:0] f);
        b.req[i]            = r;
        b.empty[i]          = e;
        b.flit_id[3*i +: 3] = f;
    endtask

    task automatic set_in2(input int i, input logic r, input logic e, input logic [2:0] f);
        b2.req[i]            = r;
        b2.empty[i]          = e;
        b2.flit_id[3*i +: 3] = f;
    endtask

    task automatic clear_inputs();
        b.req        = '0;
        b.empty      = '1;
        b.flit_id    = '0;
        b.credit_in  = 1'b0;
    endtask

    logic [4:0] seen_rd;
    logic [4:0] exp_g;
    logic [4:0] ftail;

    initial begin
        clear_inputs();
        b2.req       = '0;
        b2.empty     = '1;
        b2.flit_id   = '0;
        b2.credit_in = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_grant",   b.grant,     5'b00000);
        chk("rst_xbar",    b.xbar_sel,  3'd0);
        chk("rst_credits", b.credits,   3'd4);
        chk("rst_rd_en",   b.rd_en,     5'b00000);
        chk("rst_valid",   b.valid_out, 1'b0);
        rst = 1'b0;

        // ---------------- single packet on E ----------------
        set_in(1, 1'b1, 1'b0, `HEADER);
        #1;
        chk("sp_idle_rd_en", b.rd_en, 5'b00000);
        tick();
        chk("sp_grant", b.grant,    5'b00010);
        chk("sp_xbar",  b.xbar_sel, 3'd1);
        chk("sp_rd_h",  b.rd_en,    5'b00010);
        tick();
        set_in(1, 1'b1, 1'b0, `PAYLOAD);
        #1;
        chk("sp_rd_p",   b.rd_en,   5'b00010);
        chk("sp_cred_3", b.credits, 3'd3);
        tick();
        set_in(1, 1'b1, 1'b0, `TAIL);
        #1;
        chk("sp_rd_t",   b.rd_en,     5'b00010);
        chk("sp_valid",  b.valid_out, 1'b1);
        tick();
        set_in(1, 1'b0, 1'b1, `HEADER);
        #1;
        chk("sp_rel_grant", b.grant,     5'b00000);
        chk("sp_rel_rd_en", b.rd_en,     5'b00000);
        chk("sp_rel_ptr",   dut.r_ptr,   3'd2);
        chk("sp_rel_cred",  b.credits,   3'd1);
        chk("sp_rel_state", dut.r_state, IDLE);

        // ---------------- credit return and saturation ----------------
        b.credit_in = 1'b1;
        tick();
        tick();
        tick();
        chk("cr_full", b.credits, 3'd4);
        tick();
        chk("cr_saturate", b.credits, 3'd4);
        b.credit_in = 1'b0;

        // ---------------- lock hold ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(0, 1'b1, 1'b0, `HEADER);
        tick();
        chk("lk_grant_n", b.grant, 5'b00001);
        set_in(0, 1'b1, 1'b0, `PAYLOAD);
        set_in(3, 1'b1, 1'b0, `HEADER);
        #1;
        chk("lk_hold_1", b.grant, 5'b00001);
        chk("lk_rd_n",   b.rd_en, 5'b00001);
        tick();
        set_in(0, 1'b1, 1'b0, `TAIL);
        #1;
        chk("lk_hold_2", b.grant, 5'b00001);
        tick();
        set_in(0, 1'b0, 1'b1, `HEADER);
        #1;
        chk("lk_bubble_grant", b.grant,   5'b00000);
        chk("lk_bubble_rd",    b.rd_en,   5'b00000);
        chk("lk_ptr",          dut.r_ptr, 3'd1);
        tick();
        chk("lk_grant_s", b.grant,    5'b01000);
        chk("lk_xbar_s",  b.xbar_sel, 3'd3);

        // ---------------- fairness: all inputs, 2-flit packets ----------------
        rst = 1'b1;
        b.req       = '1;
        b.empty     = '0;
        b.credit_in = 1'b1;
        ftail       = '0;
        for (int i = 0; i < NPORTS; i++) b.flit_id[3*i +: 3] = `HEADER;
        tick();
        rst = 1'b0;
        #1;
        seen_rd = b.rd_en;
        for (int t = 1; t <= 18; t++) begin
            tick();
            for (int i = 0; i < NPORTS; i++) begin
                if (seen_rd[i]) ftail[i] = ~ftail[i];
                b.flit_id[3*i +: 3] = ftail[i] ? `TAIL : `HEADER;
            end
            #1;
            exp_g = (t % 3 == 0) ? 5'b00000 : (5'b00001 << (((t - 1) / 3) % 5));
            chk("fair_grant", b.grant, exp_g);
            seen_rd = b.rd_en;
        end
        chk("fair_credits", b.credits, 3'd4);

        // ---------------- reset mid-packet ----------------
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        set_in(0, 1'b1, 1'b0, `HEADER);
        tick();
        chk("mr_grant", b.grant, 5'b00001);
        tick();
        set_in(0, 1'b1, 1'b0, `PAYLOAD);
        rst = 1'b1;
        #1;
        chk("mr_rd_during_rst",    b.rd_en,     5'b00000);
        chk("mr_valid_during_rst", b.valid_out, 1'b0);
        tick();
        chk("mr_grant_clr", b.grant,     5'b00000);
        chk("mr_state",     dut.r_state, IDLE);
        chk("mr_credits",   b.credits,   3'd4);
        chk("mr_ptr",       dut.r_ptr,   3'd0);
        rst = 1'b0;
        set_in(0, 1'b0, 1'b1, `HEADER);
        set_in(4, 1'b1, 1'b0, `HEADER);
        tick();
        chk("mr_new_grant", b.grant,    5'b10000);
        chk("mr_new_xbar",  b.xbar_sel, 3'd4);
        set_in(4, 1'b0, 1'b1, `HEADER);

        // ---------------- credit stall, DEPTH=2 instance ----------------
        set_in2(2, 1'b1, 1'b0, `HEADER);
        tick();
        chk("cs_grant",   b2.grant,   5'b00100);
        chk("cs_cred_2",  b2.credits, 2'd2);
        b2.credit_in = 1'b1;
        #1;
        chk("cs_rd_h", b2.rd_en, 5'b00100);
        tick();
        chk("cs_simul_cred", b2.credits, 2'd2);
        b2.credit_in = 1'b0;
        set_in2(2, 1'b1, 1'b0, `PAYLOAD);
        tick();
        chk("cs_cred_1", b2.credits, 2'd1);
        tick();
        #1;
        chk("cs_stall_rd",    b2.rd_en,     5'b00000);
        chk("cs_stall_cred",  b2.credits,   2'd0);
        chk("cs_stall_valid", b2.valid_out, 1'b0);
        tick();
        chk("cs_stall_rd2",   b2.rd_en,     5'b00000);
        chk("cs_stall_grant", b2.grant,     5'b00100);
        b2.credit_in = 1'b1;
        #1;
        chk("cs_pulse_rd", b2.rd_en, 5'b00000);
        tick();
        b2.credit_in = 1'b0;
        #1;
        chk("cs_after_pulse_rd",    b2.rd_en,     5'b00100);
        chk("cs_after_pulse_valid", b2.valid_out, 1'b1);
        tick();
        set_in2(2, 1'b1, 1'b0, `TAIL);
        #1;
        chk("cs_stall_again", b2.rd_en,   5'b00000);
        chk("cs_cred_0",      b2.credits, 2'd0);
        b2.credit_in = 1'b1;
        tick();
        b2.credit_in = 1'b0;
        #1;
        chk("cs_tail_rd", b2.rd_en, 5'b00100);
        tick();
        chk("cs_rel_grant", b2.grant,   5'b00000);
        chk("cs_rel_cred",  b2.credits, 2'd0);
        chk("cs_rel_ptr",   dut2.r_ptr, 3'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
